mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0: 0 = round-robin between requesters, 1 = fixed priority, requester 0 wins.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 rK_read, rK_write  input  1 each  (K = 0,1) requester K read/write request; never both; held until rK_done.
REQ-005 rK_addr  input  16  requester K address; stable while its request is held.
REQ-006 rK_io  input  1  requester K I/O-space select.
REQ-007 rK_wdata  input  8  requester K write data.
REQ-008 rK_lock  input  1  requester K keeps ownership after its current transaction.
REQ-009 rK_rdata  output  8  read data to requester K.
REQ-010 rK_done  output  1  one-cycle completion pulse to requester K.
REQ-011 memory_read, memory_write  output  1 each  request to the shared bus-interface port.
REQ-012 memory_addr  output  16, memory_io  output  1, memory_wdata  output  8  forwarded from the owner.
REQ-013 memory_rdata  input  8, memory_done  input  1  completion from the bus-interface port.
REQ-014 busy  output  1, owner  output  1  status: transaction granted/locked, and current/last owner index.

Function
REQ-015 States: IDLE, BUSY (transaction forwarded), LOCKED (ownership held, no transaction); 2-bit encoding.
REQ-016 IDLE: pending = (rK_read|rK_write); with any pending, BUSY entered at next edge with owner chosen per REQ-017; grant latency exactly one cycle after request is seen.
REQ-017 Round-robin: both pending -> requester not equal to last owner wins; one pending -> it wins. Fixed mode: r0 wins whenever pending.
REQ-018 BUSY: memory_read/write/addr/io/wdata combinationally equal owner's inputs; in IDLE/LOCKED memory_read = memory_write = 0, memory_addr = 0, memory_wdata = 0, memory_io = 0.
REQ-019 rK_done = memory_done & BUSY & (owner == K); non-owner done is 0.
REQ-020 rK_rdata = memory_rdata for both K (qualified only by rK_done).
REQ-021 BUSY with memory_done: next state LOCKED if owner's rK_lock = 1 at that edge, else IDLE.
REQ-022 LOCKED: owner's new request -> BUSY next edge, same owner; owner's rK_lock = 0 with no request -> IDLE; other requester waits regardless.
REQ-023 No new grant issued in the cycle memory_done is high; IDLE never grants on the done edge.
REQ-024 Requester dropping its request in BUSY without done: undefined use; arbiter holds BUSY until memory_done.
REQ-025 busy = (state != IDLE); owner retains last value in IDLE.

Reset
REQ-026 rst_n low: state IDLE, owner = 1 (so r0 wins first round-robin), all rK_done = 0, memory_read = memory_write = 0, immediately and asynchronously.
REQ-027 Reset mid-BUSY abandons the transaction; no done pulse is generated; the bus-interface port shares rst_n.

Structure
REQ-028 State encodings and owner index constants SHALL live in shared package mem_arb_pkg.
REQ-029 No sub-module; selection logic is a single combinational block in mem_arbiter.

Verification
REQ-030 r0_read addr 0x1234 alone -> memory_read = 1, memory_addr = 0x1234 one cycle later; memory_done with rdata 0xA5 -> r0_done pulse, r0_rdata = 0xA5, r1_done = 0.
REQ-031 r0 and r1 write simultaneously after reset, round-robin -> r0 served first, r1 granted the cycle after r0 returns to IDLE; second round simultaneous -> r1 first? no: owner last = r1, so r0 first again; alternation verified over 4 rounds.
REQ-032 PRIORITY_MODE = 1, r0 and r1 continuously requesting -> r0 always granted, r1 granted only when r0 idle.
REQ-033 r1_lock = 1, r1 does two reads (0x0010, 0x0011) while r0 requests -> both r1 reads complete before r0 grant; r0 granted after r1_lock drops.
REQ-034 rst_n asserted during BUSY for r0 write 0x55 -> memory_write = 0 immediately, no done pulses, owner = 1 after release.
REQ-035 Formal: at most one rK_done per cycle; memory_read & memory_write never both 1; memory outputs stable while BUSY.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   arb_state_t  : arbiter FSM state encoding (2 bits)
//   OWNER_*      : requester index constants; OWNER_RESET is the owner after
//                  reset, chosen so requester 0 wins the first round-robin grant
//   pick_owner() : grant selection between the two requesters
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_t;

  localparam logic OWNER_R0    = 1'b0;
  localparam logic OWNER_R1    = 1'b1;
  localparam logic OWNER_RESET = OWNER_R1;

  // Fixed mode: r0 whenever it is pending.
  // Round-robin: the requester that did not own last, if both are pending.
  function automatic logic pick_owner(input logic pend0, input logic pend1,
                                      input logic last_owner, input logic fixed_prio);
    logic win;
    if (pend0 && pend1)
      win = fixed_prio ? OWNER_R0 : ~last_owner;
    else if (pend0)
      win = OWNER_R0;
    else
      win = OWNER_R1;
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single bus-interface memory port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rK_read/rK_write    : requester K request (held until rK_done)
//   rK_addr/io/wdata    : requester K transaction fields
//   rK_lock             : requester K keeps ownership after its transaction
//   rK_rdata, rK_done   : read data and one-cycle completion to requester K
//   memory_*            : forwarded request to / completion from the bus port
//   busy, owner         : state != IDLE, current/last owner index
//
// state  | meaning
// IDLE   | no owner active; grants on the next edge if anyone is pending
// BUSY   | owner's transaction forwarded to the bus port, awaiting memory_done
// LOCKED | owner keeps the port between transactions; the other side waits
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [15:0] r0_addr,
  input  logic        r0_io,
  input  logic [7:0]  r0_wdata,
  input  logic        r0_lock,
  output logic [7:0]  r0_rdata,
  output logic        r0_done,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [15:0] r1_addr,
  input  logic        r1_io,
  input  logic [7:0]  r1_wdata,
  input  logic        r1_lock,
  output logic [7:0]  r1_rdata,
  output logic        r1_done,
  output logic        memory_read,
  output logic        memory_write,
  output logic [15:0] memory_addr,
  output logic        memory_io,
  output logic [7:0]  memory_wdata,
  input  logic [7:0]  memory_rdata,
  input  logic        memory_done,
  output logic        busy,
  output logic        owner
);

  localparam logic FIXED_PRIO = (PRIORITY_MODE != 0);

  arb_state_t state, state_nxt;
  logic       owner_nxt;
  logic       pend0, pend1, own_pend, own_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= OWNER_RESET;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    memory_addr  = 16'h0000;
    memory_io    = 1'b0;
    memory_wdata = 8'h00;
    r0_done      = 1'b0;
    r1_done      = 1'b0;

    pend0    = r0_read | r0_write;
    pend1    = r1_read | r1_write;
    own_pend = (owner == OWNER_R1) ? pend1 : pend0;
    own_lock = (owner == OWNER_R1) ? r1_lock : r0_lock;

    case (state)
      ST_IDLE: begin
        // A stray done while idle never doubles as a grant edge.
        if ((pend0 || pend1) && !memory_done) begin
          state_nxt = ST_BUSY;
          owner_nxt = pick_owner(pend0, pend1, owner, FIXED_PRIO);
        end
      end
      ST_BUSY: begin
        if (owner == OWNER_R1) begin
          memory_read  = r1_read;
          memory_write = r1_write;
          memory_addr  = r1_addr;
          memory_io    = r1_io;
          memory_wdata = r1_wdata;
          r1_done      = memory_done;
        end else begin
          memory_read  = r0_read;
          memory_write = r0_write;
          memory_addr  = r0_addr;
          memory_io    = r0_io;
          memory_wdata = r0_wdata;
          r0_done      = memory_done;
        end
        // A dropped request without done is ignored: BUSY holds until done.
        if (memory_done)
          state_nxt = own_lock ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED: begin
        if (own_pend)
          state_nxt = ST_BUSY;
        else if (!own_lock)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign r0_rdata = memory_rdata;
  assign r1_rdata = memory_rdata;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 is round-robin, instance 1 is
// fixed priority. Each has a small bus-port responder that answers every
// request with rdata = addr[7:0] + 8'h71 two cycles after seeing it.
module tb_mem_arbiter;

  typedef struct packed {
    logic        k;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        rd [2][2];
  logic        wr [2][2];
  logic        io [2][2];
  logic        lk [2][2];
  logic [15:0] ad [2][2];
  logic [7:0]  wd [2][2];
  logic [7:0]  rdat [2][2];
  logic        dn [2][2];

  logic        m_rd [2];
  logic        m_wr [2];
  logic        m_io [2];
  logic [15:0] m_ad [2];
  logic [7:0]  m_wd [2];
  logic [7:0]  m_rdata [2];
  logic        m_done [2];
  logic        busy_o [2];
  logic        owner_o [2];
  logic        rsp_cnt [2];

  int total = 0;
  int bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.PRIORITY_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_read(rd[0][0]), .r0_write(wr[0][0]), .r0_addr(ad[0][0]), .r0_io(io[0][0]),
    .r0_wdata(wd[0][0]), .r0_lock(lk[0][0]), .r0_rdata(rdat[0][0]), .r0_done(dn[0][0]),
    .r1_read(rd[0][1]), .r1_write(wr[0][1]), .r1_addr(ad[0][1]), .r1_io(io[0][1]),
    .r1_wdata(wd[0][1]), .r1_lock(lk[0][1]), .r1_rdata(rdat[0][1]), .r1_done(dn[0][1]),
    .memory_read(m_rd[0]), .memory_write(m_wr[0]), .memory_addr(m_ad[0]),
    .memory_io(m_io[0]), .memory_wdata(m_wd[0]), .memory_rdata(m_rdata[0]),
    .memory_done(m_done[0]), .busy(busy_o[0]), .owner(owner_o[0])
  );

  mem_arbiter #(.PRIORITY_MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .r0_read(rd[1][0]), .r0_write(wr[1][0]), .r0_addr(ad[1][0]), .r0_io(io[1][0]),
    .r0_wdata(wd[1][0]), .r0_lock(lk[1][0]), .r0_rdata(rdat[1][0]), .r0_done(dn[1][0]),
    .r1_read(rd[1][1]), .r1_write(wr[1][1]), .r1_addr(ad[1][1]), .r1_io(io[1][1]),
    .r1_wdata(wd[1][1]), .r1_lock(lk[1][1]), .r1_rdata(rdat[1][1]), .r1_done(dn[1][1]),
    .memory_read(m_rd[1]), .memory_write(m_wr[1]), .memory_addr(m_ad[1]),
    .memory_io(m_io[1]), .memory_wdata(m_wd[1]), .memory_rdata(m_rdata[1]),
    .memory_done(m_done[1]), .busy(busy_o[1]), .owner(owner_o[1])
  );

  // Bus-port responder, shares rst_n with the arbiters.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_done[i]  <= 1'b0;
        m_rdata[i] <= 8'h00;
        rsp_cnt[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if ((m_rd[i] || m_wr[i]) && !m_done[i]) begin
          if (rsp_cnt[i]) begin
            m_done[i]  <= 1'b1;
            m_rdata[i] <= m_ad[i][7:0] + 8'h71;
            rsp_cnt[i] <= 1'b0;
          end else begin
            rsp_cnt[i] <= 1'b1;
          end
        end else begin
          rsp_cnt[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is presented.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dn[i][0] || dn[i][1]) begin
        exp_t e;
        logic have;
        have = 1'b0;
        e = '0;
        if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        total++;
        if (!have) begin
          bad++;
          $display("FAIL unexpected_done inst%0d: got done r0=%0b r1=%0b expected none", i, dn[i][0], dn[i][1]);
        end else begin
          chk($sformatf("done_r0 inst%0d", i), {31'd0, dn[i][0]}, {31'd0, ~e.k});
          chk($sformatf("done_r1 inst%0d", i), {31'd0, dn[i][1]}, {31'd0, e.k});
          chk($sformatf("rdata inst%0d", i), {24'd0, rdat[i][e.k]}, {24'd0, e.rdata});
          chk($sformatf("mem_addr inst%0d", i), {16'd0, m_ad[i]}, {16'd0, e.addr});
          chk($sformatf("mem_rw inst%0d", i), {30'd0, m_rd[i], m_wr[i]}, {30'd0, ~e.wr, e.wr});
          if (e.wr)
            chk($sformatf("mem_wdata inst%0d", i), {24'd0, m_wd[i]}, {24'd0, e.wdata});
        end
      end
    end
  end

  // Issue one transaction from requester k of instance inst; caller is at posedge+#1.
  task automatic req_op(input int inst, input int k, input logic is_wr,
                        input logic [15:0] addr, input logic [7:0] wdata);
    bit got;
    got = 1'b0;
    ad[inst][k] = addr;
    wd[inst][k] = wdata;
    rd[inst][k] = ~is_wr;
    wr[inst][k] = is_wr;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (dn[inst][k]) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout inst%0d r%0d: got no done expected done", inst, k);
    end
    @(posedge clk); #1;
    rd[inst][k] = 1'b0;
    wr[inst][k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        rd[i][k] = 0; wr[i][k] = 0; io[i][k] = 0; lk[i][k] = 0;
        ad[i][k] = 0; wd[i][k] = 0;
      end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_busy inst%0d", i), {31'd0, busy_o[i]}, 32'd0);
      chk($sformatf("reset_owner inst%0d", i), {31'd0, owner_o[i]}, 32'd1);
      chk($sformatf("reset_memrw inst%0d", i), {30'd0, m_rd[i], m_wr[i]}, 32'd0);
      chk($sformatf("reset_done inst%0d", i), {30'd0, dn[i][0], dn[i][1]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read from r0: grant exactly one cycle after request.
    sb0.push_back('{k: 1'b0, wr: 1'b0, addr: 16'h1234, wdata: 8'h00, rdata: 8'hA5});
    fork
      req_op(0, 0, 1'b0, 16'h1234, 8'h00);
      begin
        @(negedge clk);
        chk("latency_idle_memread", {31'd0, m_rd[0]}, 32'd0);
        @(negedge clk);
        chk("grant_memread", {31'd0, m_rd[0]}, 32'd1);
        chk("grant_memaddr", {16'd0, m_ad[0]}, 32'h1234);
        chk("grant_owner", {31'd0, owner_o[0]}, 32'd0);
        chk("grant_busy", {31'd0, busy_o[0]}, 32'd1);
      end
    join

    // Round-robin alternation over 4 rounds of simultaneous writes.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      sb0.push_back('{k: 1'b0, wr: 1'b1, addr: 16'h0100 + 16'(n), wdata: 8'h10 + 8'(n), rdata: 8'h71 + 8'(n)});
      sb0.push_back('{k: 1'b1, wr: 1'b1, addr: 16'h0200 + 16'(n), wdata: 8'h20 + 8'(n), rdata: 8'h71 + 8'(n)});
      fork
        req_op(0, 0, 1'b1, 16'h0100 + 16'(n), 8'h10 + 8'(n));
        req_op(0, 1, 1'b1, 16'h0200 + 16'(n), 8'h20 + 8'(n));
      join
      chk("rr_owner_after_round", {31'd0, owner_o[0]}, 32'd1);
    end

    // r1 locked across two reads while r0 waits.
    lk[0][1] = 1'b1;
    sb0.push_back('{k: 1'b1, wr: 1'b0, addr: 16'h0010, wdata: 8'h00, rdata: 8'h81});
    sb0.push_back('{k: 1'b1, wr: 1'b0, addr: 16'h0011, wdata: 8'h00, rdata: 8'h82});
    sb0.push_back('{k: 1'b0, wr: 1'b0, addr: 16'h0020, wdata: 8'h00, rdata: 8'h91});
    fork
      begin
        req_op(0, 1, 1'b0, 16'h0010, 8'h00);
        @(negedge clk);
        chk("locked_busy", {31'd0, busy_o[0]}, 32'd1);
        chk("locked_owner", {31'd0, owner_o[0]}, 32'd1);
        chk("locked_no_forward", {31'd0, m_rd[0]}, 32'd0);
        @(posedge clk); #1;
        req_op(0, 1, 1'b0, 16'h0011, 8'h00);
        lk[0][1] = 1'b0;
      end
      begin
        @(posedge clk); #1;
        req_op(0, 0, 1'b0, 16'h0020, 8'h00);
      end
    join

    // Reset in the middle of a BUSY write.
    wd[0][0] = 8'h55;
    ad[0][0] = 16'h0300;
    wr[0][0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_memwrite", {31'd0, m_wr[0]}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_memwrite", {31'd0, m_wr[0]}, 32'd0);
    chk("async_reset_done", {30'd0, dn[0][0], dn[0][1]}, 32'd0);
    chk("async_reset_busy", {31'd0, busy_o[0]}, 32'd0);
    wr[0][0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_owner", {31'd0, owner_o[0]}, 32'd1);
    chk("post_reset_busy", {31'd0, busy_o[0]}, 32'd0);

    // Fixed priority: r0 back-to-back keeps winning over r1.
    for (int n = 0; n < 3; n++)
      sb1.push_back('{k: 1'b0, wr: 1'b0, addr: 16'h0400 + 16'(n), wdata: 8'h00, rdata: 8'h71 + 8'(n)});
    sb1.push_back('{k: 1'b1, wr: 1'b1, addr: 16'h0500, wdata: 8'h77, rdata: 8'h71});
    fork
      for (int n = 0; n < 3; n++)
        req_op(1, 0, 1'b0, 16'h0400 + 16'(n), 8'h00);
      req_op(1, 1, 1'b1, 16'h0500, 8'h77);
    join

    repeat (3) @(posedge clk);
    chk("sb0_drained", sb0.size(), 32'd0);
    chk("sb1_drained", sb1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
